security_controller: RTL
========================

SECURITY_CONTROLLER -- requirements
Module: security_controller

Interface
REQ-001 SHALL have parameter ENTRY_DELAY, default 8, meaning cycles from an armed-sensor trip to alarm.
REQ-002 SHALL have parameter SHOW_CYCLES, default 16, meaning cycles the passcode stays displayed.
REQ-003 SHALL have parameter MAX_FAILS, default 3, meaning consecutive wrong-code entries that force alarm.
REQ-004 SHALL have the port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have the port reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have the port code, input, 4 bits: user code from switches.
REQ-007 SHALL have the port enter, input, 1 bit: one-cycle debounced submit pulse.
REQ-008 SHALL have the ports req_stay, req_away, req_reset and req_show, inputs, 1 bit each: the action selected at submit.
REQ-009 SHALL have the port door, input, 1 bit: door sensor, high = open.
REQ-010 SHALL have the port motion, input, 1 bit: motion sensor, high = detected.
REQ-011 SHALL have the port mode, output, 3 bits, registered: mode to the message display stage.
REQ-012 SHALL have the port msg, output, 4 bits, registered: message to the display stage.
REQ-013 SHALL have the port alarm, output, 1 bit, registered: siren drive.

Function
REQ-014 SHALL hold these internal states, each driving mode as shown: UNARM drives 000; ARMS drives 001; ARMA drives 010; RESET drives 011; SHOW drives 100; ALARM drives 101; ENTRY_S drives 001; ENTRY_A drives 010.
REQ-015 SHALL apply every transition and its outputs on the clock edge that samples enter or the sensor, a latency of 1 cycle.
REQ-016 SHALL define "match" as enter=1 and code equal to the stored passcode.
REQ-017 SHALL define "miss" as enter=1 and code not equal to the stored passcode.
REQ-018 In UNARM, a match SHALL select the next state by priority req_reset, then req_away, then req_stay, then req_show, going to RESET, ARMA, ARMS or SHOW respectively.
REQ-019 In UNARM, a match with no request line asserted SHALL leave the state unchanged.
REQ-020 In ARMS, door=1 SHALL go to ENTRY_S, and motion SHALL be ignored.
REQ-021 In ARMA, door=1 or motion=1 SHALL go to ENTRY_A.
REQ-022 On entering ENTRY_S or ENTRY_A, the timer SHALL load ENTRY_DELAY-1 and then decrement each cycle.
REQ-023 In ENTRY_S or ENTRY_A, the state SHALL go to ALARM on the cycle after the timer reaches 0, which is exactly ENTRY_DELAY cycles after entry.
REQ-024 Sensors SHALL be ignored while in ENTRY_S or ENTRY_A, and the timer SHALL NOT restart.
REQ-025 In ARMS, ARMA, ENTRY_S, ENTRY_A or ALARM, a match SHALL go to UNARM regardless of request lines.
REQ-026 A match SHALL win over a sensor trip or timer expiry occurring on the same cycle.
REQ-027 In RESET, the next enter SHALL latch code as the new passcode and go to SHOW; no match is required.
REQ-028 In RESET, the fail counter SHALL be unaffected.
REQ-029 On entering SHOW, the timer SHALL load SHOW_CYCLES-1.
REQ-030 SHOW SHALL return to UNARM after SHOW_CYCLES cycles, or on the cycle after any enter, whichever comes first.
REQ-031 msg SHALL equal the stored passcode in SHOW and 4'b0000 in every other state.
REQ-032 alarm SHALL be 1 only in ALARM.
REQ-033 The fail counter SHALL increment on a miss in UNARM, ARMS, ARMA, ENTRY_S or ENTRY_A, saturating at MAX_FAILS.
REQ-034 The fail counter SHALL clear on any match and on entry to UNARM.
REQ-035 The counter increment that reaches MAX_FAILS SHALL force ALARM on that same edge.
REQ-036 Misses in ALARM, RESET or SHOW SHALL NOT change the counter.
REQ-037 Request lines without enter SHALL have no effect.
REQ-038 Mode codes 110 and 111 SHALL never be produced.

Reset
REQ-039 reset=1 at a clock edge SHALL force, on that edge: state UNARM, mode=000, msg=0000, alarm=0, passcode=4'b0000, timer=0, fail counter=0.
REQ-040 Reset SHALL override all other inputs on the same edge.
REQ-041 Reset asserted mid-entry-delay or mid-alarm SHALL clear the pending alarm and restore the default passcode.

Verification
REQ-042 Bench SHALL cover: after reset, code=0000, req_away=1 and an enter pulse -> mode=010 next cycle; then motion=1 -> ENTRY_A; after 8 cycles with no enter -> mode=101 and alarm=1.
REQ-043 Bench SHALL cover: in ARMS, door=1 -> ENTRY_S; enter with code=0000 on the cycle before expiry -> mode=000 and alarm=0, and alarm never pulses.
REQ-044 Bench SHALL cover: in UNARM with passcode 0000, enter with code=0101 three times -> mode=101 and alarm=1 after the third pulse; then enter with code=0000 -> mode=000.
REQ-045 Bench SHALL cover: enter with code=0000 and req_reset=1 -> mode=011; enter with code=1010 -> mode=100 and msg=1010; after 16 cycles -> mode=000 and msg=0000; a later enter with code=0000 and req_stay=1 is a miss and stays in UNARM, while code=1010 gives mode=001.
REQ-046 Bench SHALL cover: in ARMA, motion=1 and an enter with the correct code on the same cycle -> mode=000, with no entry to ENTRY_A.
REQ-047 Bench SHALL cover: reset pulsed in ALARM after a passcode change -> mode=000, alarm=0, and passcode back to 0000.

Source files
------------

// File: rtl/security_controller.sv
// Keypad security controller: passcode-gated arm/disarm, entry delay on sensor
// trip, wrong-code lockout, and passcode change with a timed display.
module security_controller #(
  parameter int ENTRY_DELAY = 8,
  parameter int SHOW_CYCLES = 16,
  parameter int MAX_FAILS   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] code,
  input  logic       enter,
  input  logic       req_stay,
  input  logic       req_away,
  input  logic       req_reset,
  input  logic       req_show,
  input  logic       door,
  input  logic       motion,
  output logic [2:0] mode,
  output logic [3:0] msg,
  output logic       alarm
);

  localparam int TMAX = (ENTRY_DELAY > SHOW_CYCLES) ? ENTRY_DELAY : SHOW_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int FW   = $clog2(MAX_FAILS + 1);

  localparam logic [TW-1:0] ENTRY_LOAD = TW'(ENTRY_DELAY - 1);
  localparam logic [TW-1:0] SHOW_LOAD  = TW'(SHOW_CYCLES - 1);
  localparam logic [FW-1:0] FAIL_LIMIT = FW'(MAX_FAILS);

  typedef enum logic [2:0] {
    UNARM, ARMS, ARMA, RESET, SHOW, ALARM, ENTRY_S, ENTRY_A
  } state_t;

  state_t        state, state_n;
  logic [3:0]    passcode, passcode_n;
  logic [TW-1:0] timer, timer_n;
  logic [FW-1:0] fails, fails_n;
  logic [FW-1:0] fails_inc;
  logic          match, miss, counting, lockout;

  assign match     = enter && (code == passcode);
  assign miss      = enter && (code != passcode);
  assign counting  = state inside {UNARM, ARMS, ARMA, ENTRY_S, ENTRY_A};
  assign fails_inc = (fails == FAIL_LIMIT) ? fails : fails + 1'b1;
  // The miss that brings the counter to the limit trips the alarm on the same edge.
  assign lockout   = miss && counting && (fails_inc == FAIL_LIMIT);

  function automatic logic [2:0] mode_of(input state_t s);
    case (s)
      UNARM:   mode_of = 3'b000;
      ARMS:    mode_of = 3'b001;
      ARMA:    mode_of = 3'b010;
      RESET:   mode_of = 3'b011;
      SHOW:    mode_of = 3'b100;
      ALARM:   mode_of = 3'b101;
      ENTRY_S: mode_of = 3'b001;
      ENTRY_A: mode_of = 3'b010;
      default: mode_of = 3'b000;
    endcase
  endfunction

  always_comb begin
    state_n    = state;
    passcode_n = passcode;
    timer_n    = timer;
    fails_n    = fails;

    if (counting && match)     fails_n = '0;
    else if (counting && miss) fails_n = fails_inc;

    case (state)
      UNARM: begin
        if (match) begin
          if (req_reset)     state_n = RESET;
          else if (req_away) state_n = ARMA;
          else if (req_stay) state_n = ARMS;
          else if (req_show) begin
            state_n = SHOW;
            timer_n = SHOW_LOAD;
          end
        end else if (lockout) begin
          state_n = ALARM;
        end
      end
      ARMS: begin
        if (match)        state_n = UNARM;
        else if (lockout) state_n = ALARM;
        else if (door) begin
          state_n = ENTRY_S;
          timer_n = ENTRY_LOAD;
        end
      end
      ARMA: begin
        if (match)        state_n = UNARM;
        else if (lockout) state_n = ALARM;
        else if (door || motion) begin
          state_n = ENTRY_A;
          timer_n = ENTRY_LOAD;
        end
      end
      ENTRY_S, ENTRY_A: begin
        if (match)              state_n = UNARM;
        else if (lockout)       state_n = ALARM;
        else if (timer == '0)   state_n = ALARM;
        else                    timer_n = timer - 1'b1;
      end
      ALARM: begin
        if (match) state_n = UNARM;
      end
      RESET: begin
        if (enter) begin
          passcode_n = code;
          state_n    = SHOW;
          timer_n    = SHOW_LOAD;
        end
      end
      SHOW: begin
        if (enter || timer == '0) state_n = UNARM;
        else                      timer_n = timer - 1'b1;
      end
      default: state_n = UNARM;
    endcase

    if (state_n == UNARM && state != UNARM) fails_n = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= UNARM;
      passcode <= '0;
      timer    <= '0;
      fails    <= '0;
      mode     <= '0;
      msg      <= '0;
      alarm    <= 1'b0;
    end else begin
      state    <= state_n;
      passcode <= passcode_n;
      timer    <= timer_n;
      fails    <= fails_n;
      mode     <= mode_of(state_n);
      msg      <= (state_n == SHOW) ? passcode_n : '0;
      alarm    <= (state_n == ALARM);
    end
  end

endmodule
